pc_sequencer: RTL and testbench

Run-control and branch-resolution controller for the program counter. It owns the PC's reset, start, hold and relative-jump inputs. It turns decoded control signals (branch, jump, halt, stall) into single-cycle PC commands. It also holds the programmable table of jump offsets and the performance counters reported at program end.

---
 rtl/pc_sequencer.sv | 120 ++++++++++++
 tb/tb_pc_sequencer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Run-control and branch-resolution controller for the program counter.
// Holds the jump-offset table and the per-run cycle/instruction counters.
module pc_sequencer #(
  parameter int unsigned D      = 12,
  parameter int unsigned LUT_AW = 4,
  parameter int unsigned CW     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt_instr,
  input  logic              jump_en,
  input  logic              branch_en,
  input  logic              branch_cond,
  input  logic [LUT_AW-1:0] lut_idx,
  input  logic              stall,
  input  logic              cfg_we,
  input  logic [LUT_AW-1:0] cfg_addr,
  input  logic [D-1:0]      cfg_data,
  output logic              pc_reset,
  output logic              pc_start,
  output logic              pc_hold,
  output logic              reljump_en,
  output logic [D-1:0]      offset,
  output logic              busy,
  output logic              done,
  output logic [CW-1:0]     cycle_cnt,
  output logic [CW-1:0]     instr_cnt
);

  localparam int unsigned Entries = 2 ** LUT_AW;

  typedef enum logic [1:0] {StIdle, StRun, StClr, StDone} state_t;

  state_t          state_q, state_d;
  logic [D-1:0]    lut_q [Entries];
  logic [CW-1:0]   cycle_q, instr_q;
  logic            cnt_clr, take, cfg_ok;

  assign take   = jump_en | (branch_en & branch_cond);
  assign cfg_ok = cfg_we & ((state_q == StIdle) | (state_q == StDone));
  assign offset = lut_q[lut_idx];

  assign cycle_cnt = cycle_q;
  assign instr_cnt = instr_q;

  always_comb begin
    state_d    = state_q;
    pc_reset   = 1'b0;
    pc_start   = 1'b0;
    pc_hold    = 1'b0;
    reljump_en = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    cnt_clr    = 1'b0;
    unique case (state_q)
      StIdle: begin
        pc_reset = 1'b1;
        if (start) begin
          state_d = StRun;
          cnt_clr = 1'b1;
        end
      end
      StRun: begin
        busy     = 1'b1;
        pc_start = 1'b1;
        pc_hold  = stall;
        // Halt wins over a jump in the same cycle; a stalled halt waits.
        reljump_en = take & ~stall & ~halt_instr;
        if (halt_instr && !stall) state_d = StDone;
      end
      StClr: begin
        busy     = 1'b1;
        pc_reset = 1'b1;
        cnt_clr  = 1'b1;
        state_d  = StRun;
      end
      StDone: begin
        pc_hold = 1'b1;
        done    = 1'b1;
        if (start) begin
          state_d = StClr;
          cnt_clr = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else if (cnt_clr) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else if (state_q == StRun) begin
      // Counters saturate rather than wrap.
      if (cycle_q != {CW{1'b1}}) cycle_q <= cycle_q + CW'(1);
      if (!stall && instr_q != {CW{1'b1}}) instr_q <= instr_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < Entries; i++) lut_q[i] <= '0;
    end else if (cfg_ok) begin
      lut_q[cfg_addr] <= cfg_data;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer; a CW=4 copy checks counter saturation.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, halt_instr, jump_en, branch_en, branch_cond, stall, cfg_we;
  logic [3:0]  lut_idx, cfg_addr;
  logic [11:0] cfg_data;
  logic        pc_reset, pc_start, pc_hold, reljump_en, busy, done;
  logic [11:0] offset;
  logic [15:0] cycle_cnt, instr_cnt;
  logic        s_pc_reset, s_pc_start, s_pc_hold, s_reljump_en, s_busy, s_done;
  logic [11:0] s_offset;
  logic [3:0]  s_cycle_cnt, s_instr_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .halt_instr(halt_instr), .jump_en(jump_en),
    .branch_en(branch_en), .branch_cond(branch_cond), .lut_idx(lut_idx), .stall(stall),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .pc_reset(pc_reset),
    .pc_start(pc_start), .pc_hold(pc_hold), .reljump_en(reljump_en), .offset(offset),
    .busy(busy), .done(done), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  pc_sequencer #(.D(12), .LUT_AW(4), .CW(4)) dut_sat (
    .clk(clk), .reset(reset), .start(start), .halt_instr(halt_instr), .jump_en(jump_en),
    .branch_en(branch_en), .branch_cond(branch_cond), .lut_idx(lut_idx), .stall(stall),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .pc_reset(s_pc_reset),
    .pc_start(s_pc_start), .pc_hold(s_pc_hold), .reljump_en(s_reljump_en),
    .offset(s_offset), .busy(s_busy), .done(s_done), .cycle_cnt(s_cycle_cnt),
    .instr_cnt(s_instr_cnt)
  );

  typedef struct {
    int          rep;
    logic        rst, st, hlt, jmp, br, cond, stl, we;
    logic [3:0]  idx, waddr;
    logic [11:0] wdata;
    logic [5:0]  flags;  // {pc_reset, pc_start, pc_hold, reljump_en, busy, done}
    logic [11:0] off;
    logic [15:0] cyc, ins;
  } vec_t;

  localparam logic [5:0] FIdle = 6'b100000;
  localparam logic [5:0] FRun  = 6'b010010;
  localparam logic [5:0] FJmp  = 6'b010110;
  localparam logic [5:0] FStl  = 6'b011010;
  localparam logic [5:0] FDone = 6'b001001;
  localparam logic [5:0] FClr  = 6'b100010;

  vec_t tbl [$];

  task automatic check(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; start = v.st; halt_instr = v.hlt; jump_en = v.jmp; branch_en = v.br;
    branch_cond = v.cond; stall = v.stl; cfg_we = v.we; lut_idx = v.idx;
    cfg_addr = v.waddr; cfg_data = v.wdata;
  endtask

  initial begin
    // rep, rst st hlt jmp br cond stl we, idx waddr wdata, flags, off, cyc ins
    tbl.push_back('{1, 0,0,0,0,0,0,0,1, 3, 3, 12'hFFE, FIdle, 12'h000, 0, 0});
    tbl.push_back('{1, 0,0,0,0,0,0,0,1, 3, 5, 12'h004, FIdle, 12'hFFE, 0, 0});
    tbl.push_back('{1, 0,1,0,0,0,0,0,1, 5, 1, 12'h7FF, FIdle, 12'h004, 0, 0});
    tbl.push_back('{1, 0,0,0,0,0,0,0,0, 1, 0, 12'h000, FRun,  12'h7FF, 0, 0});
    tbl.push_back('{1, 0,0,0,0,0,0,0,0, 0, 0, 12'h000, FRun,  12'h000, 1, 1});
    tbl.push_back('{1, 0,0,0,0,0,0,0,0, 0, 0, 12'h000, FRun,  12'h000, 2, 2});
    tbl.push_back('{1, 0,0,0,1,0,0,0,0, 5, 0, 12'h000, FJmp,  12'h004, 3, 3});
    tbl.push_back('{1, 0,0,0,0,1,0,0,0, 3, 0, 12'h000, FRun,  12'hFFE, 4, 4});
    tbl.push_back('{1, 0,0,0,0,1,1,0,0, 3, 0, 12'h000, FJmp,  12'hFFE, 5, 5});
    tbl.push_back('{1, 0,0,0,1,0,0,1,0, 5, 0, 12'h000, FStl,  12'h004, 6, 6});
    tbl.push_back('{1, 0,0,0,1,0,0,1,0, 5, 0, 12'h000, FStl,  12'h004, 7, 6});
    tbl.push_back('{1, 0,0,1,1,0,0,1,0, 5, 0, 12'h000, FStl,  12'h004, 8, 6});
    tbl.push_back('{1, 0,0,0,0,0,0,0,1, 7, 7, 12'h123, FRun,  12'h000, 9, 6});
    tbl.push_back('{1, 0,0,0,0,0,0,0,0, 7, 0, 12'h000, FRun,  12'h000, 10, 7});
    tbl.push_back('{1, 0,0,1,1,0,0,0,0, 5, 0, 12'h000, FRun,  12'h004, 11, 8});
    tbl.push_back('{10,0,0,0,0,0,0,0,0, 0, 0, 12'h000, FDone, 12'h000, 12, 9});
    tbl.push_back('{1, 0,0,0,0,0,0,0,1, 7, 7, 12'h00A, FDone, 12'h000, 12, 9});
    tbl.push_back('{1, 0,1,0,0,0,0,0,0, 7, 0, 12'h000, FDone, 12'h00A, 12, 9});
    tbl.push_back('{1, 0,0,0,0,0,0,0,0, 0, 0, 12'h000, FClr,  12'h000, 0, 0});
    tbl.push_back('{1, 0,1,0,0,0,0,0,0, 0, 0, 12'h000, FRun,  12'h000, 0, 0});
    tbl.push_back('{1, 0,0,0,0,0,0,0,1, 9, 9, 12'h055, FRun,  12'h000, 1, 1});
    tbl.push_back('{1, 1,0,0,0,0,0,0,0, 9, 0, 12'h000, FRun,  12'h000, 2, 2});
    tbl.push_back('{1, 0,0,0,0,0,0,0,0, 9, 0, 12'h000, FIdle, 12'h000, 0, 0});

    reset = 1'b1; start = 0; halt_instr = 0; jump_en = 0; branch_en = 0; branch_cond = 0;
    stall = 0; cfg_we = 0; lut_idx = 0; cfg_addr = 0; cfg_data = 0;
    repeat (2) @(negedge clk);

    foreach (tbl[r]) begin
      for (int k = 0; k < tbl[r].rep; k++) begin
        drive(tbl[r]);
        #1;
        check("flags", r, 32'(
          {pc_reset, pc_start, pc_hold, reljump_en, busy, done}), 32'(tbl[r].flags));
        check("offset", r, 32'(offset), 32'(tbl[r].off));
        check("cycle_cnt", r, 32'(cycle_cnt), 32'(tbl[r].cyc));
        check("instr_cnt", r, 32'(instr_cnt), 32'(tbl[r].ins));
        @(negedge clk);
      end
    end

    // After the mid-run reset the whole table must read back as zero.
    reset = 0; cfg_we = 0; start = 0;
    for (int i = 0; i < 16; i++) begin
      lut_idx = 4'(i);
      #1;
      check("table_cleared", 100 + i, 32'(offset), 32'h0);
    end

    // Run long enough to saturate the 4-bit counters of the small instance.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    stall = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("cycle_cnt_long", 200, 32'(cycle_cnt), 32'd23);
    check("instr_cnt_long", 200, 32'(instr_cnt), 32'd20);
    check("cycle_cnt_sat", 200, 32'(s_cycle_cnt), 32'd15);
    check("instr_cnt_sat", 200, 32'(s_instr_cnt), 32'd15);
    check("busy_sat", 200, 32'(s_busy), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
